game_datapath: RTL and testbench

- Datapath for the sequence-memory game. It executes the control commands r1, r2, e1–e4 and sel from the game FSM, and returns the status flags end_fpga, end_user, end_time, win and match to it.
- It holds the random sequence, replays it on the LEDs, captures and checks user entries, times each round, and keeps the score.
- It sits between the FSM and the board I/O: switches, debounced enter pulse, LEDs and score display.

---
 rtl/game_pkg.sv | 32 +++
 rtl/game_timer.sv | 47 ++++
 rtl/game_datapath.sv | 185 ++++++++++++++++++
 tb/tb_game_datapath.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the sequence-memory game: command/status bit positions,
// LFSR seed and step, and the round-counter width helper.
package game_pkg;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam int CMD_R1  = 0;
    localparam int CMD_R2  = 1;
    localparam int CMD_E1  = 2;
    localparam int CMD_E2  = 3;
    localparam int CMD_E3  = 4;
    localparam int CMD_E4  = 5;
    localparam int CMD_SEL = 6;
    localparam int CMD_W   = 7;

    localparam int ST_END_FPGA = 0;
    localparam int ST_END_USER = 1;
    localparam int ST_END_TIME = 2;
    localparam int ST_WIN      = 3;
    localparam int ST_MATCH    = 4;
    localparam int ST_W        = 5;

    function automatic int round_width(input int n_rounds);
        return $clog2(n_rounds + 1);
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/game_timer.sv
// Tick prescaler plus saturating tick counter; end_time is held once the limit
// is reached until clear or reset.
module game_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int LIMIT    = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic count_en,
    output logic tick,
    output logic end_time
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(LIMIT + 1);

    logic [PW-1:0] presc_r;
    logic [TW-1:0] time_cnt_r;
    logic          end_time_r;

    assign tick     = run && (presc_r == PW'(TICK_DIV - 1));
    assign end_time = end_time_r;

    // Prescaler and saturating time counter
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            presc_r    <= '0;
            time_cnt_r <= '0;
            end_time_r <= 1'b0;
        end else begin
            if (run) begin
                presc_r <= tick ? '0 : presc_r + 1'b1;
            end
            if (tick && count_en && !end_time_r) begin
                if (time_cnt_r == TW'(LIMIT - 1)) begin
                    time_cnt_r <= TW'(LIMIT);
                    end_time_r <= 1'b1;
                end else begin
                    time_cnt_r <= time_cnt_r + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/game_datapath.sv
// Datapath of the sequence-memory game: sequence fill, LED replay, entry
// checking, round timing and score keeping, driven by the game FSM commands.
module game_datapath import game_pkg::*; #(
    parameter int  N_ROUNDS   = 16,
    parameter int  DISP_TICKS = 2,
    parameter int  TIME_LIMIT = 10,
    parameter int  TICK_DIV   = 50000000,
    localparam int ROUND_W    = round_width(N_ROUNDS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               r1,
    input  logic               r2,
    input  logic               e1,
    input  logic               e2,
    input  logic               e3,
    input  logic               e4,
    input  logic               sel,
    input  logic               enter,
    input  logic [3:0]         switches,
    output logic               end_fpga,
    output logic               end_user,
    output logic               end_time,
    output logic               win,
    output logic               match,
    output logic [3:0]         leds,
    output logic [ROUND_W-1:0] score,
    output logic               won
);

    localparam int IDX_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
    localparam int DC_W  = (DISP_TICKS > 1) ? $clog2(DISP_TICKS) : 1;

    logic [CMD_W-1:0]   cmd_s;
    logic [ST_W-1:0]    status_s;
    logic               clr_s;
    logic               tick_s;
    logic               end_time_s;
    logic               win_s;

    logic [7:0]         lfsr_r;
    logic [3:0]         seq_mem [N_ROUNDS];
    logic [IDX_W-1:0]   fill_ptr_r;
    logic [ROUND_W-1:0] round_r;
    logic               err_r;
    logic [ROUND_W-1:0] disp_idx_r;
    logic [DC_W-1:0]    disp_cnt_r;
    logic [ROUND_W-1:0] user_cnt_r;
    logic               end_fpga_r;
    logic               end_user_r;
    logic [ROUND_W-1:0] score_r;
    logic               won_r;

    // Gather the FSM commands into the shared bit layout
    always_comb begin
        cmd_s          = '0;
        cmd_s[CMD_R1]  = r1;
        cmd_s[CMD_R2]  = r2;
        cmd_s[CMD_E1]  = e1;
        cmd_s[CMD_E2]  = e2;
        cmd_s[CMD_E3]  = e3;
        cmd_s[CMD_E4]  = e4;
        cmd_s[CMD_SEL] = sel;
    end

    assign clr_s = cmd_s[CMD_R1] | cmd_s[CMD_R2];
    assign win_s = (round_r == ROUND_W'(N_ROUNDS));

    game_timer #(
        .TICK_DIV (TICK_DIV),
        .LIMIT    (TIME_LIMIT)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (clr_s),
        .run      (cmd_s[CMD_E2] | cmd_s[CMD_E3]),
        .count_en (cmd_s[CMD_E2]),
        .tick     (tick_s),
        .end_time (end_time_s)
    );

    // Sequence memory write during setup; contents are not reset
    always_ff @(posedge clock) begin
        if (!reset && cmd_s[CMD_E1]) begin
            seq_mem[fill_ptr_r] <= lfsr_r[3:0] ^ switches;
        end
    end

    // Game state: LFSR, fill pointer, display, entry check, round and result
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_r     <= LFSR_SEED;
            fill_ptr_r <= '0;
            round_r    <= '0;
            err_r      <= 1'b0;
            disp_idx_r <= '0;
            disp_cnt_r <= '0;
            user_cnt_r <= '0;
            end_fpga_r <= 1'b0;
            end_user_r <= 1'b0;
            score_r    <= '0;
            won_r      <= 1'b0;
        end else begin
            if (cmd_s[CMD_E1]) begin
                lfsr_r <= lfsr_step(lfsr_r);
            end
            if (cmd_s[CMD_R1]) begin
                fill_ptr_r <= '0;
            end else if (cmd_s[CMD_E1]) begin
                fill_ptr_r <= (fill_ptr_r == IDX_W'(N_ROUNDS - 1)) ? '0 : fill_ptr_r + 1'b1;
            end

            if (clr_s) begin
                err_r      <= 1'b0;
                disp_idx_r <= '0;
                disp_cnt_r <= '0;
                user_cnt_r <= '0;
                end_fpga_r <= 1'b0;
                end_user_r <= 1'b0;
                if (cmd_s[CMD_R1]) begin
                    round_r <= '0;
                end
            end else begin
                // Each element dwells DISP_TICKS ticks; the last one of this round ends the replay
                if (cmd_s[CMD_E3] && !end_fpga_r && tick_s) begin
                    if (disp_cnt_r == DC_W'(DISP_TICKS - 1)) begin
                        disp_cnt_r <= '0;
                        if (disp_idx_r == round_r) begin
                            end_fpga_r <= 1'b1;
                        end else begin
                            disp_idx_r <= disp_idx_r + 1'b1;
                        end
                    end else begin
                        disp_cnt_r <= disp_cnt_r + 1'b1;
                    end
                end
                if (cmd_s[CMD_E2] && !end_user_r && enter) begin
                    if (switches != seq_mem[user_cnt_r[IDX_W-1:0]]) begin
                        err_r <= 1'b1;
                    end
                    user_cnt_r <= user_cnt_r + 1'b1;
                    if (user_cnt_r == round_r) begin
                        end_user_r <= 1'b1;
                    end
                end
                if (cmd_s[CMD_E4] && !err_r && (round_r < ROUND_W'(N_ROUNDS))) begin
                    round_r <= round_r + 1'b1;
                end
            end

            if (cmd_s[CMD_SEL]) begin
                score_r <= round_r;
                won_r   <= win_s;
            end
        end
    end

    // LEDs show the current element only while the replay is in progress
    always_comb begin
        if (cmd_s[CMD_E3] && !end_fpga_r) begin
            leds = seq_mem[disp_idx_r[IDX_W-1:0]];
        end else begin
            leds = 4'h0;
        end
    end

    // Status flags back to the FSM in the shared bit layout
    always_comb begin
        status_s              = '0;
        status_s[ST_END_FPGA] = end_fpga_r;
        status_s[ST_END_USER] = end_user_r;
        status_s[ST_END_TIME] = end_time_s;
        status_s[ST_WIN]      = win_s;
        status_s[ST_MATCH]    = ~err_r;
    end

    assign end_fpga = status_s[ST_END_FPGA];
    assign end_user = status_s[ST_END_USER];
    assign end_time = status_s[ST_END_TIME];
    assign win      = status_s[ST_WIN];
    assign match    = status_s[ST_MATCH];
    assign score    = score_r;
    assign won      = won_r;

endmodule

// File: tb/tb_game_datapath.sv
// Randomized scoreboard bench for game_datapath against a game-rule reference model.
module tb_game_datapath;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int TL = 10;
    localparam int RW = $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          r1 = 1'b0, r2 = 1'b0, e1 = 1'b0, e2 = 1'b0, e3 = 1'b0, e4 = 1'b0, sel = 1'b0;
    logic          enter = 1'b0;
    logic [3:0]    sw = 4'h0;
    logic          end_fpga, end_user, end_time, win, match, won;
    logic [3:0]    leds;
    logic [RW-1:0] score;

    game_datapath #(.N_ROUNDS(N), .DISP_TICKS(D), .TIME_LIMIT(TL), .TICK_DIV(1)) dut (
        .clock(clock), .reset(reset), .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3), .e4(e4),
        .sel(sel), .enter(enter), .switches(sw), .end_fpga(end_fpga), .end_user(end_user),
        .end_time(end_time), .win(win), .match(match), .leds(leds), .score(score), .won(won)
    );

    always #5 clock = ~clock;

    typedef struct { int kind; int exp; } exp_t;
    exp_t sb_q[$];
    logic smp = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, kept in game terms
    logic [7:0] m_lfsr;
    int m_mem[N];
    int m_fill, m_round, m_shown, m_entries, m_tcnt, m_score;
    bit m_err, m_end_fpga, m_end_user, m_won;

    function automatic string kname(input int k);
        case (k)
            0: return "leds";     1: return "end_fpga"; 2: return "end_user"; 3: return "end_time";
            4: return "win";      5: return "match";    6: return "score";    7: return "won";
            default: return "unknown";
        endcase
    endfunction

    function automatic int observe(input int k);
        case (k)
            0: return int'(leds);     1: return int'(end_fpga); 2: return int'(end_user);
            3: return int'(end_time); 4: return int'(win);      5: return int'(match);
            6: return int'(score);    7: return int'(won);
            default: return -1;
        endcase
    endfunction

    // Monitor: whenever the DUT outputs are presented for checking, drain the scoreboard
    always @(negedge clock) begin
        exp_t e;
        int   act;
        if (smp) begin
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = observe(e.kind);
                n_cmp++;
                if (act != e.exp) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %0d expected %0d", kname(e.kind), $time, act, e.exp);
                end
            end
        end
    end

    function automatic logic [7:0] model_lfsr_next(input logic [7:0] s);
        int   taps[4] = '{8, 6, 5, 4};
        logic fb;
        fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i] - 1];
        return {s[6:0], fb};
    endfunction

    task automatic push_expect();
        int exp_leds;
        exp_leds = (e3 && !m_end_fpga) ? m_mem[m_shown / D] : 0;
        sb_q.push_back('{0, exp_leds});
        sb_q.push_back('{1, int'(m_end_fpga)});
        sb_q.push_back('{2, int'(m_end_user)});
        sb_q.push_back('{3, (m_tcnt >= TL) ? 1 : 0});
        sb_q.push_back('{4, (m_round == N) ? 1 : 0});
        sb_q.push_back('{5, m_err ? 0 : 1});
        sb_q.push_back('{6, m_score});
        sb_q.push_back('{7, int'(m_won)});
    endtask

    // Apply the game rules for one clock edge with the inputs currently driven
    task automatic model_edge();
        if (reset) begin
            m_lfsr = 8'hA5; m_fill = 0; m_round = 0; m_err = 0; m_shown = 0; m_entries = 0;
            m_tcnt = 0; m_end_fpga = 0; m_end_user = 0; m_score = 0; m_won = 0;
        end else begin
            if (sel) begin m_score = m_round; m_won = (m_round == N); end
            if (e1) begin
                m_mem[m_fill] = int'(m_lfsr[3:0] ^ sw);
                m_lfsr = model_lfsr_next(m_lfsr);
            end
            if (r1) m_fill = 0;
            else if (e1) m_fill = (m_fill + 1) % N;
            if (r1 || r2) begin
                m_err = 0; m_shown = 0; m_entries = 0; m_tcnt = 0; m_end_fpga = 0; m_end_user = 0;
                if (r1) m_round = 0;
            end else begin
                if (e3 && !m_end_fpga) begin
                    m_shown++;
                    if (m_shown == D * (m_round + 1)) m_end_fpga = 1;
                end
                if (e2 && enter && !m_end_user) begin
                    if (int'(sw) != m_mem[m_entries]) m_err = 1;
                    m_entries++;
                    if (m_entries == m_round + 1) m_end_user = 1;
                end
                if (e2 && m_tcnt < TL) m_tcnt++;
                if (e4 && !m_err && m_round < N) m_round++;
            end
        end
    endtask

    // One clock cycle: optional check of the present outputs, then the edge
    task automatic cyc(input bit chk);
        if (chk) begin
            push_expect();
            smp = 1'b1;
        end
        @(negedge clock);
        #1 smp = 1'b0;
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_r2();
        r2 = 1'b1; cyc(1); r2 = 1'b0;
    endtask

    task automatic run_display();
        e3 = 1'b1;
        repeat (D * (m_round + 1) + 2) cyc(1);
        e3 = 1'b0;
        pulse_r2();
    endtask

    task automatic do_entry(input logic [3:0] v);
        e2 = 1'b1; enter = 1'b1; sw = v;
        cyc(1);
        enter = 1'b0;
        cyc(1);
    endtask

    task automatic end_round();
        e2 = 1'b0;
        e4 = 1'b1; cyc(1); e4 = 1'b0;
        sel = 1'b1; cyc(1); sel = 1'b0;
        cyc(1);
        pulse_r2();
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = 0;
        @(posedge clock); #1;
        cyc(0); cyc(0);
        reset = 1'b0;
        cyc(1);

        // Fill from the seed with switches at zero, then reset restarts the LFSR
        e1 = 1'b1; sw = 4'h0;
        repeat (5) cyc(0);
        e1 = 1'b0;
        reset = 1'b1; cyc(0); reset = 1'b0;
        cyc(1);
        run_display();

        // Wrong entry keeps round 0, correct entry advances to round 1
        do_entry(4'(m_mem[0]) ^ 4'hF);
        end_round();
        do_entry(4'(m_mem[0]));
        end_round();
        run_display();

        // Round-reset mid-entry, enter outside e2, extra enter after completion
        do_entry(4'(m_mem[0]));
        e2 = 1'b0;
        pulse_r2();
        enter = 1'b1; sw = 4'(m_mem[0]) ^ 4'h5; cyc(1); enter = 1'b0; cyc(1);
        do_entry(4'(m_mem[0]));
        do_entry(4'(m_mem[1]));
        do_entry(4'(m_mem[1]) ^ 4'h3);
        end_round();
        r1 = 1'b1; cyc(1); r1 = 1'b0; cyc(1);

        // Time-out, and an entry landing on the final tick
        e2 = 1'b1;
        repeat (TL + 3) cyc(1);
        e2 = 1'b0;
        pulse_r2();
        e2 = 1'b1;
        repeat (TL - 1) cyc(1);
        enter = 1'b1; sw = 4'(m_mem[0]); cyc(1); enter = 1'b0;
        cyc(1);
        e2 = 1'b0;
        pulse_r2();

        // Game reset aborts a replay in progress
        e3 = 1'b1; cyc(1); cyc(1);
        e3 = 1'b0; r1 = 1'b1; cyc(1); r1 = 1'b0; cyc(1);

        // Randomized games: random fills, random right/wrong entries
        for (int g = 0; g < 6; g++) begin
            r1 = 1'b1; cyc(0); r1 = 1'b0;
            e1 = 1'b1;
            repeat ($urandom_range(1, 7)) begin
                sw = 4'($urandom_range(0, 15));
                cyc(0);
            end
            e1 = 1'b0;
            for (int a = 0; a < 6 && m_round < N; a++) begin
                run_display();
                for (int k = 0; k <= m_round; k++) begin
                    if ($urandom_range(0, 3) != 0) do_entry(4'(m_mem[k]));
                    else do_entry(4'(m_mem[k]) ^ 4'($urandom_range(1, 15)));
                end
                end_round();
            end
        end

        cyc(1);
        @(negedge clock); #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
